// File: rtl/mux4_rr_arbiter_pkg.sv
// ============================================================================
// Module  : mux4_rr_arbiter_pkg
// Brief   : Shared constants and helpers for the 4-way round-robin mux arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mux4_rr_arbiter_pkg;

    localparam int c_N_REQ = 4;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    localparam logic [1:0] c_SEL_E0 = 2'b00;
    localparam logic [1:0] c_SEL_E1 = 2'b01;
    localparam logic [1:0] c_SEL_E2 = 2'b10;
    localparam logic [1:0] c_SEL_E3 = 2'b11;

    function automatic logic [c_N_REQ-1:0] sel_to_onehot(input logic [1:0] s);
        case (s)
            c_SEL_E0: sel_to_onehot = 4'b0001;
            c_SEL_E1: sel_to_onehot = 4'b0010;
            c_SEL_E2: sel_to_onehot = 4'b0100;
            default:  sel_to_onehot = 4'b1000;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// ============================================================================
// Module  : rr_pick4
// Brief   : Combinational rotating-priority search over four requests.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick4 (
    input  logic [3:0] req,
    input  logic [3:0] mask,
    input  logic [1:0] last,
    output logic       found,
    output logic [1:0] idx
);
    logic [3:0] w_cand;
    logic [1:0] w_pos;

    assign w_cand = req & ~mask;

    // Walk from the lowest priority (last) up to last+1 so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = last;
        w_pos = last;
        for (int k = 4; k >= 1; k--) begin
            w_pos = last + 2'(k);
            if (w_cand[w_pos]) begin
                found = 1'b1;
                idx   = w_pos;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
// ============================================================================
// Module  : mux4_rr_arbiter
// Brief   : Burst-limited round-robin arbiter driving a 4:1 mux select.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4_rr_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             sel_valid,
    output logic [CNT_W-1:0] busy_cnt
);
    import mux4_rr_arbiter_pkg::*;

    localparam logic [CNT_W-1:0] c_BURST_LAST = CNT_W'(MAX_BURST - 1);

    logic [0:0]       r_state, w_state_nxt;
    logic [3:0]       r_gnt,   w_gnt_nxt;
    logic [1:0]       r_sel,   w_sel_nxt;
    logic [1:0]       r_last,  w_last_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;

    logic [3:0] w_pick_mask;
    logic [1:0] w_pick_last;
    logic       w_pick_found;
    logic [1:0] w_pick_idx;
    logic       w_owner_req;
    logic       w_burst_end;

    // While busy, the owner is masked out and becomes the lowest priority.
    assign w_pick_mask = (r_state == c_ST_BUSY) ? sel_to_onehot(r_sel) : 4'b0000;
    assign w_pick_last = (r_state == c_ST_BUSY) ? r_sel : r_last;
    assign w_owner_req = req[r_sel];
    assign w_burst_end = (r_cnt == c_BURST_LAST);

    rr_pick4 u_pick (
        .req   (req),
        .mask  (w_pick_mask),
        .last  (w_pick_last),
        .found (w_pick_found),
        .idx   (w_pick_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = c_ST_BUSY;
                    w_gnt_nxt   = sel_to_onehot(w_pick_idx);
                    w_sel_nxt   = w_pick_idx;
                    w_cnt_nxt   = '0;
                end
            end
            c_ST_BUSY: begin
                if (!w_owner_req || w_burst_end) begin
                    w_last_nxt = r_sel;
                    w_cnt_nxt  = '0;
                    if (w_pick_found) begin
                        w_gnt_nxt = sel_to_onehot(w_pick_idx);
                        w_sel_nxt = w_pick_idx;
                    end else if (!w_owner_req) begin
                        // Nobody else waiting and owner done: sel keeps its last value.
                        w_state_nxt = c_ST_IDLE;
                        w_gnt_nxt   = 4'b0000;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_gnt_nxt   = 4'b0000;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= c_SEL_E0;
            r_last  <= c_SEL_E3;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign sel_valid = |r_gnt;
    assign busy_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
// ============================================================================
// Module  : tb_mux4_rr_arbiter
// Brief   : Self-checking bench for mux4_rr_arbiter at MAX_BURST = 8, 2 and 1.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux4_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] req;

    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic [1:0] sel_a, sel_b, sel_c;
    logic       val_a, val_b, val_c;
    logic [3:0] cnt_a, cnt_b, cnt_c;

    mux4_rr_arbiter #(.MAX_BURST(8), .CNT_W(4)) u_dut_mb8 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_a), .sel(sel_a), .sel_valid(val_a), .busy_cnt(cnt_a)
    );
    mux4_rr_arbiter #(.MAX_BURST(2), .CNT_W(4)) u_dut_mb2 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_b), .sel(sel_b), .sel_valid(val_b), .busy_cnt(cnt_b)
    );
    mux4_rr_arbiter #(.MAX_BURST(1), .CNT_W(4)) u_dut_mb1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_c), .sel(sel_c), .sel_valid(val_c), .busy_cnt(cnt_c)
    );

    // Observed outputs packed as {gnt, sel, sel_valid, busy_cnt}.
    logic [10:0] obs [3];
    assign obs[0] = {gnt_a, sel_a, val_a, cnt_a};
    assign obs[1] = {gnt_b, sel_b, val_b, cnt_b};
    assign obs[2] = {gnt_c, sel_c, val_c, cnt_c};

    int errors = 0;
    int checks = 0;

    // Reference model: owner as an integer (-1 = none), held cycle count, last owner.
    int max_burst [3] = '{8, 2, 1};
    int own  [3];
    int held [3];
    int lst  [3];
    int msel [3];

    function automatic int rr_search(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        for (int m = 0; m < 3; m++) begin
            if (!rst_n) begin
                own[m] = -1; held[m] = 0; lst[m] = 3; msel[m] = 0;
            end else if (own[m] < 0) begin
                w = rr_search(req, lst[m]);
                if (w >= 0) begin own[m] = w; msel[m] = w; held[m] = 0; end
            end else if (req[own[m]] && held[m] < max_burst[m] - 1) begin
                held[m] = held[m] + 1;
            end else begin
                lst[m] = own[m];
                w = rr_search(req & ~(4'b0001 << own[m]), lst[m]);
                held[m] = 0;
                if (w >= 0) begin own[m] = w; msel[m] = w; end
                else if (!req[own[m]]) own[m] = -1;
            end
        end
    endtask

    function automatic logic [10:0] expect_vec(input int m);
        logic [3:0] g;
        g = (own[m] >= 0) ? 4'(1 << own[m]) : 4'b0000;
        return {g, 2'(msel[m]), own[m] >= 0, 4'(held[m])};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst_n = 1'b0;
        req   = r;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        tick();
        tick();
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (obs[m] !== 11'b0) begin
                errors++;
                $display("FAIL reset_state[%0d] got=%b exp=%b", m, obs[m], 11'b0);
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            tick();
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (obs[m] !== expect_vec(m)) begin
                    errors++;
                    $display("FAIL reset_model[%0d] c=%0d got=%b exp=%b", m, c, obs[m], expect_vec(m));
                end
            end
            checks++;
            if (c < 8 && {gnt_a, sel_a, cnt_a} !== {4'b0001, 2'b00, 4'(c)}) begin
                errors++;
                $display("FAIL reset_owner0 c=%0d got gnt=%b sel=%b cnt=%0d", c, gnt_a, sel_a, cnt_a);
            end else if (c == 8 && {gnt_a, sel_a, cnt_a} !== {4'b0010, 2'b01, 4'd0}) begin
                errors++;
                $display("FAIL reset_owner1 got gnt=%b sel=%b cnt=%0d exp gnt=0010 sel=01 cnt=0", gnt_a, sel_a, cnt_a);
            end
        end
    endtask

    task automatic test_single();
        do_reset(4'b0000);
        req = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 2) req = 4'b0000;
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (obs[m] !== expect_vec(m)) begin
                    errors++;
                    $display("FAIL single_model[%0d] c=%0d got=%b exp=%b", m, c, obs[m], expect_vec(m));
                end
            end
            checks++;
            if (c < 3 && gnt_a !== 4'b0100) begin
                errors++;
                $display("FAIL single_gnt c=%0d got=%b exp=0100", c, gnt_a);
            end else if (c >= 3 && {gnt_a, sel_a, val_a} !== {4'b0000, 2'b10, 1'b0}) begin
                errors++;
                $display("FAIL single_idle c=%0d got gnt=%b sel=%b val=%b exp 0000/10/0", c, gnt_a, sel_a, val_a);
            end
        end
    endtask

    task automatic test_handover();
        logic [3:0] seq [4] = '{4'b0010, 4'b1010, 4'b1010, 4'b1000};
        do_reset(4'b0000);
        for (int c = 0; c < 4; c++) begin
            req = seq[c];
            tick();
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (obs[m] !== expect_vec(m)) begin
                    errors++;
                    $display("FAIL handover_model[%0d] c=%0d got=%b exp=%b", m, c, obs[m], expect_vec(m));
                end
            end
        end
        checks++;
        if ({gnt_a, sel_a, val_a, cnt_a} !== {4'b1000, 2'b11, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL handover got gnt=%b sel=%b val=%b cnt=%0d exp 1000/11/1/0", gnt_a, sel_a, val_a, cnt_a);
        end
    endtask

    task automatic test_fairness();
        int tally [4] = '{0, 0, 0, 0};
        do_reset(4'b0000);
        req = 4'b1111;
        for (int t = 0; t < 64; t++) begin
            tick();
            for (int i = 0; i < 4; i++) if (gnt_b[i]) tally[i]++;
            checks++;
            if (gnt_b !== 4'(1 << ((t / 2) % 4))) begin
                errors++;
                $display("FAIL fair_order t=%0d got=%b exp=%b", t, gnt_b, 4'(1 << ((t / 2) % 4)));
            end
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (obs[m] !== expect_vec(m)) begin
                    errors++;
                    $display("FAIL fair_model[%0d] t=%0d got=%b exp=%b", m, t, obs[m], expect_vec(m));
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tally[i] != 16) begin
                errors++;
                $display("FAIL fair_tally[%0d] got=%0d exp=16", i, tally[i]);
            end
        end
    endtask

    task automatic test_forced();
        do_reset(4'b0000);
        req = 4'b0100;
        for (int t = 0; t < 20; t++) begin
            tick();
            checks++;
            if ({gnt_a, cnt_a} !== {4'b0100, 4'(t % 8)}) begin
                errors++;
                $display("FAIL forced t=%0d got gnt=%b cnt=%0d exp gnt=0100 cnt=%0d", t, gnt_a, cnt_a, t % 8);
            end
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (obs[m] !== expect_vec(m)) begin
                    errors++;
                    $display("FAIL forced_model[%0d] t=%0d got=%b exp=%b", m, t, obs[m], expect_vec(m));
                end
            end
        end
    endtask

    task automatic test_midreset();
        do_reset(4'b0000);
        req = 4'b1000;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (obs[m] !== 11'b0) begin
                errors++;
                $display("FAIL midreset_clear[%0d] got=%b exp=%b", m, obs[m], 11'b0);
            end
        end
        rst_n = 1'b1;
        req   = 4'b1001;
        tick();
        checks++;
        if ({gnt_a, sel_a, gnt_c} !== {4'b0001, 2'b00, 4'b0001}) begin
            errors++;
            $display("FAIL midreset_first got gnt=%b sel=%b gnt_mb1=%b exp 0001/00/0001", gnt_a, sel_a, gnt_c);
        end
    endtask

    task automatic test_random();
        do_reset(4'b0000);
        for (int t = 0; t < 500; t++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            rst_n = ($urandom_range(0, 63) != 0);
            tick();
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (obs[m] !== expect_vec(m)) begin
                    errors++;
                    $display("FAIL random_model[%0d] t=%0d req=%b got=%b exp=%b", m, t, req, obs[m], expect_vec(m));
                end
            end
            checks++;
            if (!$onehot0(gnt_a) || !$onehot0(gnt_b) || !$onehot0(gnt_c) ||
                val_a != |gnt_a || val_b != |gnt_b || val_c != |gnt_c) begin
                errors++;
                $display("FAIL random_invariant t=%0d got gnt=%b/%b/%b val=%b%b%b exp one-hot0 with val==|gnt",
                         t, gnt_a, gnt_b, gnt_c, val_a, val_b, val_c);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        test_reset();
        test_single();
        test_handover();
        test_fairness();
        test_forced();
        test_midreset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
